button_debouncer: RTL and testbench
===================================

Name: button_debouncer

Overview:
Conditions the raw DE0-Nano push-button pin into a clean, glitch-free level.
- Synchronises the asynchronous pin into the i_clk domain.
- Removes contact bounce with a stability counter and a 4-state FSM.
- Drives o_level directly into the downstream rising-edge detector's level input, so each physical press yields exactly one clean level transition.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, clock cycles the synchronised input must remain changed before o_level follows (20 ms at 50 MHz); legal range >= 1
BUTTON_ACTIVE_LOW, 1, 1 = pin reads 0 when pressed (DE0-Nano KEYs), 0 = pin reads 1 when pressed

Ports:
i_clk  input  1  system clock from PLL; all state updates on rising edge
i_rst_n  input  1  asynchronous, active-low reset; deasserted synchronously to i_clk by the top level
i_button  input  1  raw push-button pin, asynchronous, may bounce
o_level  output  1  debounced, polarity-corrected level: 1 = pressed; registered
o_bouncing  output  1  1 while a candidate transition is being qualified (WAIT_* states); registered-state decode

Behaviour:
Reset (i_rst_n = 0, asynchronous):
- Both sync flops load the released pin value (1 if BUTTON_ACTIVE_LOW, else 0).
- FSM = STABLE_LOW, counter = 0, o_level = 0, o_bouncing = 0.
- Reset mid-qualification discards the pending transition.

Synchroniser:
- Two flops in series.
- s = second flop XOR BUTTON_ACTIVE_LOW, so s = 1 means pressed.
- No logic between the flops.

Counter:
- Width $clog2(DEBOUNCE_CYCLES).
- Minimum width 1.
- Never wraps; the terminal compare is cnt == DEBOUNCE_CYCLES-1.

FSM states and transitions (evaluated each rising edge):
- STABLE_LOW: o_level = 0.
  - s = 1 -> WAIT_HIGH, cnt <= 0.
  - Otherwise stay.
- WAIT_HIGH: o_level = 0.
  - s = 0 (bounce) -> STABLE_LOW, cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1 -> STABLE_HIGH, o_level <= 1, cnt <= 0.
  - Else cnt <= cnt+1.
- STABLE_HIGH: o_level = 1.
  - s = 0 -> WAIT_LOW, cnt <= 0.
- WAIT_LOW: o_level = 1.
  - s = 1 -> STABLE_HIGH, cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1 -> STABLE_LOW, o_level <= 0, cnt <= 0.
  - Else cnt <= cnt+1.
- Any unreachable encoding -> STABLE_LOW.

Latency:
- Let edge k be the first edge at which sync flop 1 captures the new pin value, with the pin held constant afterwards.
- o_level changes immediately after edge k+2+DEBOUNCE_CYCLES.
- o_bouncing = 1 from edge k+2 until that same edge.

Boundary conditions:
- Any single-cycle reversal of s during WAIT_* aborts the transition and restarts qualification from zero on the next change.
- Pulses shorter than DEBOUNCE_CYCLES+1 synchronised cycles never reach o_level.
- o_level never toggles on two consecutive edges; minimum spacing between o_level changes is DEBOUNCE_CYCLES+1 cycles.
- DEBOUNCE_CYCLES = 1 is legal: WAIT_* lasts exactly one cycle.
- Pin held pressed through reset deassertion:
  - Synchroniser flushes within 2 cycles.
  - o_level rises after the normal latency.
  - The downstream edge detector therefore sees one press.

Decomposition:
- Shared package holds:
  - Enum typedef for the FSM: STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW, 2-bit encoding.
  - Constant for the default debounce cycles (1_000_000).
  - Constant for the simulation debounce value (4).
- One sub-module: sync_2ff.
  - Parameterised reset value.
  - Async active-low reset.
  - Reusable for other pin inputs.

Test Plan:
- DEBOUNCE_CYCLES = 4, active-low. Reset held 3 cycles with pin = 1, then release -> o_level = 0, o_bouncing = 0, FSM = STABLE_LOW.
- Clean press: pin 1->0, first captured at edge k, held -> o_bouncing rises after k+2; o_level = 1 after edge k+6, not before.
- Bounce: pin 0 for 3 cycles, 1 for 1 cycle, repeated 5 times, then held 0 -> o_level stays 0 throughout the bounce and rises exactly 6 edges after the final capture of 0.
- Release with a 1-cycle glitch back to pressed inside WAIT_LOW -> returns to STABLE_HIGH, counter restarts; o_level falls only after an uninterrupted 6-edge release.
- Assert i_rst_n low asynchronously (mid-cycle) while in WAIT_HIGH with cnt = 2 -> o_level = 0 and o_bouncing = 0 immediately, without waiting for a clock edge.
- Chain with the edge detector, 10 presses with random bounce of 0-3 cycles per edge -> exactly 10 single-cycle ticks; o_level change spacing >= 5 cycles.

Source files
------------

// File: rtl/button_debouncer_pkg.sv
// Shared types and constants for the push-button debouncer.
// Holds the FSM state enum, debounce defaults and a counter-width helper.
package button_debouncer_pkg;

   typedef enum logic [1:0] {
      STABLE_LOW  = 2'b00,
      WAIT_HIGH   = 2'b01,
      STABLE_HIGH = 2'b10,
      WAIT_LOW    = 2'b11
   } db_state_t;

   localparam int DEBOUNCE_DEFAULT = 1_000_000;
   localparam int DEBOUNCE_SIM     = 4;

   // Counter must hold 0..n-1 and never be zero bits wide.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/button_debouncer_sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Ports: i_clk, i_rst_n (async low), i_d (async in), o_q (synchronised).
module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic meta;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         meta <= RST_VAL;
         o_q  <= RST_VAL;
      end else begin
         meta <= i_d;
         o_q  <= meta;
      end
   end

endmodule

// File: rtl/button_debouncer.sv
// Debounces a raw push-button pin into a clean active-high level.
// Ports: i_clk, i_rst_n, i_button (raw pin), o_level, o_bouncing.
module button_debouncer
   import button_debouncer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES   = DEBOUNCE_DEFAULT,
   parameter bit BUTTON_ACTIVE_LOW = 1'b1
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_button,
   output logic o_level,
   output logic o_bouncing
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic      pin_q;
   logic      s;
   db_state_t state, state_d;
   logic [CW-1:0] cnt, cnt_d;
   logic      level, level_d;

   // Reset to the released pin value so no phantom press is seen.
   sync_2ff #(
      .RST_VAL (BUTTON_ACTIVE_LOW)
   ) u_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (i_button),
      .o_q     (pin_q)
   );

   // s = 1 means pressed regardless of pin polarity.
   assign s = pin_q ^ BUTTON_ACTIVE_LOW;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= STABLE_LOW;
         cnt   <= '0;
         level <= 1'b0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         level <= level_d;
      end
   end

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      level_d = level;
      case (state)
         STABLE_LOW: begin
            level_d = 1'b0;
            if (s) begin
               state_d = WAIT_HIGH;
               cnt_d   = '0;
            end
         end
         WAIT_HIGH: begin
            level_d = 1'b0;
            if (!s) begin
               state_d = STABLE_LOW;
               cnt_d   = '0;
            end else if (cnt == CNT_LAST) begin
               state_d = STABLE_HIGH;
               level_d = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         STABLE_HIGH: begin
            level_d = 1'b1;
            if (!s) begin
               state_d = WAIT_LOW;
               cnt_d   = '0;
            end
         end
         WAIT_LOW: begin
            level_d = 1'b1;
            if (s) begin
               state_d = STABLE_HIGH;
               cnt_d   = '0;
            end else if (cnt == CNT_LAST) begin
               state_d = STABLE_LOW;
               level_d = 1'b0;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         default: begin
            state_d = STABLE_LOW;
            cnt_d   = '0;
            level_d = 1'b0;
         end
      endcase
   end

   assign o_level    = level;
   assign o_bouncing = (state == WAIT_HIGH) || (state == WAIT_LOW);

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer (4-cycle debounce, active-low).
// Run-length reference model plus directed literal checks.
module tb_button_debouncer;
   import button_debouncer_pkg::*;

   localparam int DC = DEBOUNCE_SIM;
   localparam logic PR  = 1'b0;
   localparam logic REL = 1'b1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic btn = REL;
   logic o_level;
   logic o_bouncing;

   int n_vec = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   button_debouncer #(
      .DEBOUNCE_CYCLES   (DC),
      .BUTTON_ACTIVE_LOW (1'b1)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_button   (btn),
      .o_level    (o_level),
      .o_bouncing (o_bouncing)
   );

   // Reference: the level flips once the pressed/released view of the
   // pin (two samples late) has disagreed with it for DC+1 edges in a row.
   logic [1:0] m_hist;
   int m_run;
   bit m_level;
   wire m_bouncing = (m_run != 0);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_hist  <= 2'b00;
         m_run   <= 0;
         m_level <= 1'b0;
      end else begin
         automatic bit s = m_hist[1];
         automatic int run = (s != m_level) ? m_run + 1 : 0;
         m_hist <= {m_hist[0], (btn == PR)};
         if (run == DC + 1) begin
            m_level <= !m_level;
            m_run   <= 0;
         end else begin
            m_run <= run;
         end
      end
   end

   task automatic check(input string name, input logic got, input logic exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b want %b at %0t", name, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_level", o_level, m_level);
         check("model_bouncing", o_bouncing, m_bouncing);
      end
   end

   // Downstream rising-edge detector and spacing monitor.
   logic det_q;
   int ticks = 0;
   int cyc = 0;
   int last_chg = -1000;
   logic lvl_prev = 1'b0;
   bit chain_en = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) det_q <= 1'b0;
      else        det_q <= o_level;
   end

   always @(negedge clk) begin
      cyc++;
      if (chain_en) begin
         if (o_level && !det_q) ticks++;
         if (o_level !== lvl_prev) begin
            check("change_spacing", (cyc - last_chg) >= DC + 1, 1'b1);
            last_chg = cyc;
         end
      end
      lvl_prev = o_level;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset with pin released.
      rst_n = 1'b0;
      btn = REL;
      chk_en = 1'b1;
      #1;
      check("rst_level", o_level, 1'b0);
      check("rst_bouncing", o_bouncing, 1'b0);
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (2) tick();
      check("idle_level", o_level, 1'b0);
      check("idle_bouncing", o_bouncing, 1'b0);

      // Clean press: edge k is the first capture.
      btn = PR;
      tick();
      for (int i = 1; i <= 6; i++) begin
         tick();
         check("press_level", o_level, i >= 6);
         check("press_bouncing", o_bouncing, (i >= 2) && (i < 6));
      end
      repeat (3) tick();
      check("press_hold", o_level, 1'b1);

      // Clean release back to low.
      btn = REL;
      repeat (10) tick();
      check("release_level", o_level, 1'b0);

      // Bounce: 3 pressed, 1 released, five times.
      repeat (5) begin
         btn = PR;
         repeat (3) begin
            tick();
            check("bounce_level", o_level, 1'b0);
         end
         btn = REL;
         tick();
         check("bounce_level", o_level, 1'b0);
      end
      btn = PR;
      tick();
      repeat (5) begin
         tick();
         check("bounce_settle_low", o_level, 1'b0);
      end
      tick();
      check("bounce_settle_high", o_level, 1'b1);
      repeat (3) tick();

      // Release with a one-cycle glitch back to pressed.
      btn = REL;
      tick();
      tick();
      btn = PR;
      tick();
      btn = REL;
      tick();
      tick();
      check("glitch_abort_bouncing", o_bouncing, 1'b0);
      check("glitch_abort_level", o_level, 1'b1);
      tick();
      check("glitch_requal_bouncing", o_bouncing, 1'b1);
      repeat (3) begin
         tick();
         check("glitch_hold_level", o_level, 1'b1);
      end
      tick();
      check("glitch_fall_level", o_level, 1'b0);
      check("glitch_fall_bouncing", o_bouncing, 1'b0);
      repeat (3) tick();

      // Async reset mid-qualification (WAIT_HIGH, cnt = 2).
      btn = PR;
      tick();
      repeat (4) tick();
      check("pre_rst_bouncing", o_bouncing, 1'b1);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_rst_level", o_level, 1'b0);
      check("async_rst_bouncing", o_bouncing, 1'b0);
      tick();

      // Pin held pressed through reset release.
      rst_n = 1'b1;
      tick();
      repeat (5) begin
         tick();
         check("held_rst_low", o_level, 1'b0);
      end
      tick();
      check("held_rst_high", o_level, 1'b1);
      repeat (2) tick();

      // Async reset while stable high drops the level at once.
      #3;
      rst_n = 1'b0;
      #1;
      check("async_rst_high_level", o_level, 1'b0);
      tick();
      btn = REL;
      rst_n = 1'b1;
      repeat (4) tick();

      // Chained edge detector: 10 bouncy presses.
      ticks = 0;
      lvl_prev = o_level;
      chain_en = 1'b1;
      for (int p = 0; p < 10; p++) begin
         automatic int nb = $urandom_range(0, 3);
         repeat (nb) begin
            btn = PR;
            tick();
            btn = REL;
            tick();
         end
         btn = PR;
         repeat (12) tick();
         nb = $urandom_range(0, 3);
         repeat (nb) begin
            btn = REL;
            tick();
            btn = PR;
            tick();
         end
         btn = REL;
         repeat (12) tick();
      end
      repeat (4) tick();
      n_vec++;
      if (ticks != 10) begin
         n_bad++;
         $display("FAIL chain_ticks: got %0d want 10", ticks);
      end

      chk_en = 1'b0;
      chain_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
